ps2_key_fifo: RTL and testbench
===============================

Name: ps2_key_fifo

Overview:
- Keyboard front end for the Next186Lite core; sits between hps_io's ps2_key output and the core's keyboard port.
- Converts each hps_io key event into a PS/2 set-2 byte sequence (optional E0 prefix, optional F0 break code, then the scan code).
- Buffers the bytes in a first-word-fall-through FIFO that the core drains through a read strobe.
- Asserts an interrupt request while data is pending.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth in bytes (depth = 16 at default).

Ports:
clk_sys  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
ps2_key  in  11  hps_io key event: [10] toggle strobe, [9] pressed, [8] extended, [7:0] scan code.
rd  in  1  one-cycle pop strobe from the core.
clr_ovf  in  1  clears the overflow flag.
dout  out  8  byte at the FIFO head.
valid  out  1  FIFO non-empty.
irq  out  1  interrupt request; registered copy of valid.
level  out  DEPTH_LOG2+1  number of bytes stored.
overflow  out  1  sticky flag: a key event was dropped.

Behaviour:
- Event detect:
  - Register prev_tog holds the last seen ps2_key[10].
  - An event occurs in cycle T when ps2_key[10] != prev_tog.
  - prev_tog updates every cycle.
- Byte count per event: need = 1 + ps2_key[8] + !ps2_key[9]. Range 1..3.
- Acceptance, in cycle T:
  - Accept only if the sequencer is IDLE and (2^DEPTH_LOG2 - level) >= need.
  - Free space is sampled in cycle T; a pop in cycle T is not counted.
  - On accept, latch ext, rel and code.
  - Otherwise drop the whole event and set overflow. Partial sequences are never written.
- Sequencer FSM, states IDLE, PUT_E0, PUT_F0, PUT_CODE:
  - IDLE -> PUT_E0 on accept if ext; else -> PUT_F0 if rel; else -> PUT_CODE.
  - PUT_E0 writes 0xE0, then goes to PUT_F0 if rel, else PUT_CODE.
  - PUT_F0 writes 0xF0, then goes to PUT_CODE.
  - PUT_CODE writes code, then goes to IDLE.
  - Exactly one byte is written per non-IDLE cycle.
  - An event arriving while the FSM is not IDLE is dropped and sets overflow.
- FIFO:
  - Circular buffer with wr_ptr/rd_ptr of DEPTH_LOG2 bits; both wrap modulo depth.
  - level is a separate counter with range 0..2^DEPTH_LOG2.
  - First-word fall-through, registered: a byte written in cycle W appears on dout, with valid=1, in cycle W+1 if the FIFO was empty.
  - rd while valid=1: the head advances; dout shows the next byte in the following cycle.
  - rd while valid=0 is ignored; no pointer or level change.
  - Write and pop in the same cycle: level unchanged, both pointers advance.
  - dout is don't-care while valid=0. It must not be X after reset; it resets to 0x00.
- Latency: press of a non-extended key (code only) appears on dout/valid at T+2 relative to the toggle cycle.
- irq = valid delayed by one register stage.
- overflow:
  - Set on any dropped event.
  - Cleared by clr_ovf in the following cycle.
  - If set and clear coincide in one cycle, set wins.
- Reset:
  - Applies regardless of FSM state (mid-sequence included).
  - Empties the FIFO: pointers and level 0, valid=0, irq=0, dout=0x00, overflow=0.
  - FSM goes to IDLE.
  - prev_tog <= ps2_key[10], so no spurious event after reset.
  - No partially written sequence survives reset.

Test Plan:
1. After reset, flip ps2_key[10] with pressed=1, ext=0, code=0x1C -> valid=1 and dout=0x1C at T+2, level=1; irq=1 at T+3; rd pop -> valid=0, level=0.
2. Release of an extended key, code=0x75 (ps2_key[9]=0, [8]=1) -> FIFO receives 0xE0, 0xF0, 0x75 in consecutive cycles; level=3; three pops return them in that order.
3. Fill to level=14, then inject an extended release (need=3) -> event dropped, level stays 14, overflow=1. A following plain press (need=1) is accepted: level=15, overflow stays 1. Pulse clr_ovf -> overflow=0.
4. Two toggles one cycle apart, the first an extended break -> second event dropped, overflow=1, only 3 bytes stored.
5. With level=2, assert rd in the same cycle the FSM writes a byte -> level stays 2, and the order is preserved across 20 events so both pointers wrap past 15.
6. Assert reset during PUT_F0 while ps2_key[10] is held at 1 -> FIFO empty, valid=0, overflow=0, FSM IDLE; no event is detected after reset until the toggle changes.

Source files
------------

// File: rtl/ps2_key_fifo.sv
// PS/2 set-2 keyboard front end: turns hps_io key events into E0/F0/code bytes in a FWFT FIFO.
// Latency: plain make code on dout/valid 2 cycles after the toggle; events dropped (sticky overflow) when busy or short of space.
module ps2_key_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic [10:0]           ps2_key,
    input  logic                  rd,
    input  logic                  clr_ovf,
    output logic [7:0]            dout,
    output logic                  valid,
    output logic                  irq,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] C_DEPTH = (DEPTH_LOG2+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PUT_E0,
        S_PUT_F0,
        S_PUT_CODE
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_prev_tog;
    logic                   r_ext;
    logic                   r_rel;
    logic [7:0]             r_code;
    logic [7:0]             r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  r_wr_ptr;
    logic [DEPTH_LOG2-1:0]  r_rd_ptr;
    logic [DEPTH_LOG2:0]    r_level;
    logic                   r_valid;
    logic                   r_irq;
    logic                   r_ovf;
    logic [7:0]             r_dout;

    logic                   w_event;
    logic [DEPTH_LOG2:0]    w_need;
    logic [DEPTH_LOG2:0]    w_free;
    logic                   w_accept;
    logic                   w_drop;
    logic                   w_wr;
    logic [7:0]             w_wr_dat;
    logic                   w_pop;
    logic [DEPTH_LOG2-1:0]  w_rd_ptr_nxt;
    logic [DEPTH_LOG2:0]    w_level_nxt;
    logic [7:0]             w_head_nxt;

    // Space is judged on the registered level only; a pop in the same cycle does not help.
    assign w_event  = ps2_key[10] ^ r_prev_tog;
    assign w_need   = (DEPTH_LOG2+1)'(1) + (DEPTH_LOG2+1)'(ps2_key[8]) + (DEPTH_LOG2+1)'(!ps2_key[9]);
    assign w_free   = C_DEPTH - r_level;
    assign w_accept = w_event && (r_state == S_IDLE) && (w_free >= w_need);
    assign w_drop   = w_event && !w_accept;

    always_comb begin
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        w_wr_dat    = r_code;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (ps2_key[8])
                        w_state_nxt = S_PUT_E0;
                    else if (!ps2_key[9])
                        w_state_nxt = S_PUT_F0;
                    else
                        w_state_nxt = S_PUT_CODE;
                end
            end
            S_PUT_E0: begin
                w_wr        = 1'b1;
                w_wr_dat    = 8'hE0;
                w_state_nxt = r_rel ? S_PUT_F0 : S_PUT_CODE;
            end
            S_PUT_F0: begin
                w_wr        = 1'b1;
                w_wr_dat    = 8'hF0;
                w_state_nxt = S_PUT_CODE;
            end
            S_PUT_CODE: begin
                w_wr        = 1'b1;
                w_wr_dat    = r_code;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_pop        = rd && r_valid;
    assign w_rd_ptr_nxt = w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;

    always_comb begin
        w_level_nxt = r_level;
        case ({w_wr, w_pop})
            2'b10:   w_level_nxt = r_level + 1'b1;
            2'b01:   w_level_nxt = r_level - 1'b1;
            default: w_level_nxt = r_level;
        endcase
    end

    // The byte being written becomes the head when the FIFO is empty after this cycle's pop.
    assign w_head_nxt = (w_wr && (w_rd_ptr_nxt == r_wr_ptr)) ? w_wr_dat : r_mem[w_rd_ptr_nxt];

    always_ff @(posedge clk_sys) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= w_wr_dat;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_prev_tog <= ps2_key[10];
            r_state    <= S_IDLE;
            r_ext      <= 1'b0;
            r_rel      <= 1'b0;
            r_code     <= 8'h00;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_valid    <= 1'b0;
            r_dout     <= 8'h00;
            r_irq      <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_prev_tog <= ps2_key[10];
            r_state    <= w_state_nxt;
            if (w_accept) begin
                r_ext  <= ps2_key[8];
                r_rel  <= !ps2_key[9];
                r_code <= ps2_key[7:0];
            end
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_level  <= w_level_nxt;
            r_valid  <= (w_level_nxt != '0);
            r_dout   <= (w_level_nxt != '0) ? w_head_nxt : 8'h00;
            r_irq    <= r_valid;
            if (w_drop)
                r_ovf <= 1'b1;
            else if (clr_ovf)
                r_ovf <= 1'b0;
        end
    end

    assign dout     = r_dout;
    assign valid    = r_valid;
    assign irq      = r_irq;
    assign level    = r_level;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Directed bench for ps2_key_fifo: byte sequencing, FWFT timing, overflow policy, pointer wrap, reset mid-sequence.
module tb_ps2_key_fifo;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic        rd;
    logic        clr_ovf;
    logic [7:0]  dout;
    logic        valid;
    logic        irq;
    logic [4:0]  level;
    logic        overflow;

    int          total = 0;
    int          bad   = 0;
    logic        tog   = 1'b0;
    logic [7:0]  q [$];
    logic [7:0]  exp_b;

    always #5 clk_sys = ~clk_sys;

    ps2_key_fifo #(.DEPTH_LOG2(4)) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ps2_key  (ps2_key),
        .rd       (rd),
        .clr_ovf  (clr_ovf),
        .dout     (dout),
        .valid    (valid),
        .irq      (irq),
        .level    (level),
        .overflow (overflow)
    );

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic ev(input logic pr, input logic ex, input logic [7:0] code);
        tog     = ~tog;
        ps2_key = {tog, pr, ex, code};
    endtask

    initial begin
        reset   = 1'b1;
        ps2_key = 11'h000;
        rd      = 1'b0;
        clr_ovf = 1'b0;
        step();
        step();
        reset = 1'b0;
        chk("rst_valid", 16'(valid), 16'h0);
        chk("rst_level", 16'(level), 16'h0);
        chk("rst_dout", 16'(dout), 16'h00);
        chk("rst_irq", 16'(irq), 16'h0);
        chk("rst_ovf", 16'(overflow), 16'h0);

        // 1: plain make code, latency and irq
        ev(1'b1, 1'b0, 8'h1C);
        step();
        chk("t1_valid_T1", 16'(valid), 16'h0);
        step();
        chk("t1_valid_T2", 16'(valid), 16'h1);
        chk("t1_dout_T2", 16'(dout), 16'h1C);
        chk("t1_level_T2", 16'(level), 16'h1);
        chk("t1_irq_T2", 16'(irq), 16'h0);
        step();
        chk("t1_irq_T3", 16'(irq), 16'h1);
        rd = 1'b1;
        step();
        rd = 1'b0;
        chk("t1_pop_valid", 16'(valid), 16'h0);
        chk("t1_pop_level", 16'(level), 16'h0);
        step();
        chk("t1_irq_drop", 16'(irq), 16'h0);
        rd = 1'b1;
        step();
        rd = 1'b0;
        chk("t1_rd_empty_level", 16'(level), 16'h0);

        // 2: extended break -> E0 F0 75
        ev(1'b0, 1'b1, 8'h75);
        step();
        step();
        chk("t2_lvl1", 16'(level), 16'h1);
        chk("t2_head", 16'(dout), 16'hE0);
        step();
        chk("t2_lvl2", 16'(level), 16'h2);
        step();
        chk("t2_lvl3", 16'(level), 16'h3);
        step();
        chk("t2_lvl3_hold", 16'(level), 16'h3);
        q = '{8'hE0, 8'hF0, 8'h75};
        for (int i = 0; i < 3; i++) begin
            exp_b = q.pop_front();
            chk("t2_pop_dout", 16'(dout), 16'(exp_b));
            rd = 1'b1;
            step();
        end
        rd = 1'b0;
        chk("t2_empty", 16'(valid), 16'h0);

        // 3: fill to 14, overflow on need=3, accept need=1, fill to full
        for (int i = 1; i <= 14; i++) begin
            ev(1'b1, 1'b0, 8'(i));
            q.push_back(8'(i));
            step();
            step();
        end
        chk("t3_lvl14", 16'(level), 16'd14);
        ev(1'b0, 1'b1, 8'h11);
        step();
        chk("t3_ovf_set", 16'(overflow), 16'h1);
        step();
        step();
        step();
        chk("t3_lvl14_after_drop", 16'(level), 16'd14);
        ev(1'b1, 1'b0, 8'h22);
        q.push_back(8'h22);
        step();
        step();
        chk("t3_lvl15", 16'(level), 16'd15);
        chk("t3_ovf_sticky", 16'(overflow), 16'h1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("t3_ovf_clr", 16'(overflow), 16'h0);
        ev(1'b1, 1'b0, 8'h33);
        q.push_back(8'h33);
        step();
        step();
        chk("t3_lvl16", 16'(level), 16'd16);
        chk("t3_ovf_still0", 16'(overflow), 16'h0);
        ev(1'b1, 1'b0, 8'h44);
        step();
        chk("t3_full_drop_ovf", 16'(overflow), 16'h1);
        step();
        chk("t3_full_lvl", 16'(level), 16'd16);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_b = q.pop_front();
            chk("t3_drain_dout", 16'(dout), 16'(exp_b));
            rd = 1'b1;
            step();
        end
        rd = 1'b0;
        chk("t3_drained_lvl", 16'(level), 16'h0);
        chk("t3_drained_valid", 16'(valid), 16'h0);

        // 4: second toggle while busy is dropped
        ev(1'b0, 1'b1, 8'h6B);
        step();
        ev(1'b1, 1'b0, 8'h44);
        step();
        chk("t4_ovf", 16'(overflow), 16'h1);
        step();
        step();
        step();
        chk("t4_lvl3", 16'(level), 16'h3);
        q = '{8'hE0, 8'hF0, 8'h6B};
        for (int i = 0; i < 3; i++) begin
            exp_b = q.pop_front();
            chk("t4_dout", 16'(dout), 16'(exp_b));
            rd = 1'b1;
            step();
        end
        rd = 1'b0;
        chk("t4_lvl0", 16'(level), 16'h0);

        // 5: simultaneous write and pop at level 2, pointers wrap
        ev(1'b1, 1'b0, 8'h50);
        q.push_back(8'h50);
        step();
        step();
        ev(1'b1, 1'b0, 8'h51);
        q.push_back(8'h51);
        step();
        step();
        chk("t5_lvl2", 16'(level), 16'h2);
        for (int i = 0; i < 20; i++) begin
            ev(1'b1, 1'b0, 8'(8'h60 + i));
            q.push_back(8'(8'h60 + i));
            step();
            exp_b = q.pop_front();
            chk("t5_dout", 16'(dout), 16'(exp_b));
            rd = 1'b1;
            step();
            rd = 1'b0;
            chk("t5_lvl", 16'(level), 16'h2);
        end
        chk("t5_ovf_kept", 16'(overflow), 16'h1);

        // 6: reset during PUT_F0 with toggle held high
        ev(1'b0, 1'b0, 8'h12);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_lvl", 16'(level), 16'h0);
        chk("t6_valid", 16'(valid), 16'h0);
        chk("t6_ovf", 16'(overflow), 16'h0);
        chk("t6_dout", 16'(dout), 16'h00);
        chk("t6_irq", 16'(irq), 16'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t6_quiet_lvl", 16'(level), 16'h0);
        end
        chk("t6_quiet_ovf", 16'(overflow), 16'h0);
        ev(1'b1, 1'b0, 8'h29);
        step();
        step();
        chk("t6_post_valid", 16'(valid), 16'h1);
        chk("t6_post_dout", 16'(dout), 16'h29);
        chk("t6_post_lvl", 16'(level), 16'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
